// File: rtl/dice_roll_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dice_roll_ctrl
// Purpose  : Button-triggered dice roll: animated face value, final latch,
//            done pulse, lockout, completed-roll counter and pause input.
// Revision : 1.0
// ============================================================================
module dice_roll_ctrl #(
  parameter int STEP_CYCLES = 5_000_000,
  parameter int ROLL_STEPS  = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       stop,
  input  logic       btn,
  output logic [2:0] dice_val,
  output logic       rolling,
  output logic       done,
  output logic [7:0] roll_count
);

  localparam int DIV_W  = $clog2(STEP_CYCLES);
  localparam int STEP_W = $clog2(ROLL_STEPS) + 1;

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(STEP_CYCLES - 1);
  localparam logic [DIV_W-1:0]  DIV_ONE   = DIV_W'(1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(ROLL_STEPS - 1);
  localparam logic [STEP_W-1:0] STEP_ONE  = STEP_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ROLL = 2'd1,
    HOLD = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [2:0]        seed_q, seed_d;
  logic              btn_q;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [2:0]        dice_q, dice_d;
  logic              rolling_q, rolling_d;
  logic              done_q, done_d;
  logic [7:0]        count_q, count_d;
  logic              rise;

  assign rise = btn & ~btn_q;

  always_comb begin
    state_d   = state_q;
    seed_d    = seed_q;
    div_d     = div_q;
    step_d    = step_q;
    dice_d    = dice_q;
    rolling_d = rolling_q;
    done_d    = 1'b0;
    count_d   = count_q;

    // While paused everything holds; a rise seen now is simply lost.
    if (!stop) begin
      seed_d = (seed_q == 3'd6) ? 3'd1 : seed_q + 3'd1;
      case (state_q)
        IDLE: begin
          if (rise) begin
            state_d   = ROLL;
            div_d     = '0;
            step_d    = '0;
            rolling_d = 1'b1;
          end
        end
        ROLL: begin
          if (div_q == DIV_LAST) begin
            div_d  = '0;
            dice_d = seed_q;
            if (step_q == STEP_LAST) begin
              done_d    = 1'b1;
              rolling_d = 1'b0;
              count_d   = count_q + 8'd1;
              state_d   = HOLD;
            end else begin
              step_d = step_q + STEP_ONE;
            end
          end else begin
            div_d = div_q + DIV_ONE;
          end
        end
        HOLD: begin
          if (div_q == DIV_LAST) begin
            div_d   = '0;
            state_d = IDLE;
          end else begin
            div_d = div_q + DIV_ONE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      seed_q    <= 3'd1;
      btn_q     <= 1'b0;
      div_q     <= '0;
      step_q    <= '0;
      dice_q    <= 3'd1;
      rolling_q <= 1'b0;
      done_q    <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      seed_q    <= seed_d;
      btn_q     <= btn;
      div_q     <= div_d;
      step_q    <= step_d;
      dice_q    <= dice_d;
      rolling_q <= rolling_d;
      done_q    <= done_d;
      count_q   <= count_d;
    end
  end

  assign dice_val   = dice_q;
  assign rolling    = rolling_q;
  assign done       = done_q;
  assign roll_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_dice_roll_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dice_roll_ctrl
// Purpose  : Self-checking bench for dice_roll_ctrl against an elapsed-time
//            reference model.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_dice_roll_ctrl;

  localparam int SC = 4;
  localparam int RS = 3;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic       stop  = 1'b0;
  logic       btn   = 1'b0;
  logic [2:0] dice_val;
  logic       rolling;
  logic       done;
  logic [7:0] roll_count;

  dice_roll_ctrl #(
    .STEP_CYCLES(SC),
    .ROLL_STEPS (RS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .stop      (stop),
    .btn       (btn),
    .dice_val  (dice_val),
    .rolling   (rolling),
    .done      (done),
    .roll_count(roll_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int edge_n  = 0;

  // Reference model: a roll is an interval of unpaused cycles since acceptance.
  int m_seed, m_elapsed, m_dice, m_count;
  bit m_busy, m_done, m_rolling, m_btn_prev;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, edge_n);
    end
  endtask

  task automatic model_reset();
    m_seed = 1; m_elapsed = 0; m_dice = 1; m_count = 0;
    m_busy = 0; m_done = 0; m_rolling = 0; m_btn_prev = 0;
  endtask

  task automatic model_edge(input bit b, input bit s);
    bit r;
    int seed_pre;
    r = b & ~m_btn_prev;
    m_btn_prev = b;
    m_done = 0;
    if (!s) begin
      seed_pre = m_seed;
      m_seed = (m_seed % 6) + 1;
      if (m_busy) begin
        m_elapsed++;
        if ((m_elapsed % SC) == 0 && m_elapsed <= RS * SC) m_dice = seed_pre;
        if (m_elapsed == RS * SC) begin
          m_done  = 1;
          m_count = (m_count + 1) % 256;
        end
        if (m_elapsed == (RS + 1) * SC) m_busy = 0;
      end else if (r) begin
        m_busy = 1;
        m_elapsed = 0;
      end
    end
    m_rolling = m_busy && (m_elapsed < RS * SC);
  endtask

  task automatic step(input bit b, input bit s);
    btn  = b;
    stop = s;
    @(posedge clk);
    edge_n++;
    model_edge(b, s);
    #1;
    chk("dice_val", dice_val, m_dice);
    chk("rolling", rolling, m_rolling);
    chk("done", done, m_done);
    chk("roll_count", roll_count, m_count);
    chk("dice_range", (dice_val >= 3'd1 && dice_val <= 3'd6), 1);
  endtask

  task automatic do_reset();
    btn   = 1'b0;
    stop  = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_dice", dice_val, 1);
    chk("rst_rolling", rolling, 0);
    chk("rst_done", done, 0);
    chk("rst_count", roll_count, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n  = 1'b1;
    edge_n = 0;
    model_reset();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c0, guard;
    bit b;
    model_reset();
    #2;
    do_reset();

    // Basic roll then lockout: rise at edge 10, ignored rise at 24, fresh rise at 27.
    for (int n = 1; n <= 30; n++) begin
      step((n == 10 || n == 11 || n == 24 || n == 27), 1'b0);
      if (n == 10) chk("basic_rolling_e10", rolling, 1);
      if (n == 14) chk("basic_dice_e14", dice_val, 2);
      if (n == 18) chk("basic_dice_e18", dice_val, 6);
      if (n == 21) chk("basic_done_e21", done, 0);
      if (n == 22) begin
        chk("basic_dice_e22", dice_val, 4);
        chk("basic_done_e22", done, 1);
        chk("basic_rolling_e22", rolling, 0);
        chk("basic_count_e22", roll_count, 1);
      end
      if (n == 26) chk("lock_count_e26", roll_count, 1);
      if (n == 27) chk("lock_rolling_e27", rolling, 1);
    end

    // Pause during the roll defers completion to edge 27.
    do_reset();
    for (int n = 1; n <= 32; n++) begin
      step((n == 10), (n >= 15 && n <= 19));
      if (n == 17) chk("pause_done_e17", done, 0);
      if (n == 26) chk("pause_done_e26", done, 0);
      if (n == 27) begin
        chk("pause_done_e27", done, 1);
        chk("pause_dice_e27", dice_val, 4);
        chk("pause_count_e27", roll_count, 1);
      end
    end

    // Button held across roll and lockout starts only one roll.
    c0 = m_count;
    step(1'b0, 1'b0);
    repeat (40) step(1'b1, 1'b0);
    chk("held_count", roll_count, (c0 + 1) % 256);
    chk("held_rolling", rolling, 0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    chk("held_rerise", rolling, 1);

    // Reset mid-roll aborts with no completion.
    repeat (5) step(1'b0, 1'b0);
    do_reset();

    // Random button/pause traffic.
    b = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0) b = ~b;
      step(b, ($urandom_range(0, 9) < 2));
    end

    // 256 completed rolls wrap the counter back to zero.
    do_reset();
    for (int r = 0; r < 256; r++) begin
      step(1'b1, 1'b0);
      guard = 0;
      while (m_busy && guard < 200) begin
        step(1'b0, ($urandom_range(0, 9) == 0));
        guard++;
      end
      if (guard >= 200) chk("wrap_timeout", 0, 1);
      if (r == 254) chk("wrap_count_255", roll_count, 255);
    end
    chk("wrap_count_0", roll_count, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dice_roll_ctrl.md
# dice_roll_ctrl

Dice-roll controller that sits directly downstream of the button debouncer in the dice-throwing design. It takes the debounced, level-stable button signal and starts a roll on each rising edge. During the roll it animates the face value at a fixed step rate, then latches a final 1..6 value, pulses `done`, and enforces a short lockout. It also counts completed rolls and honours the shared `stop` (pause) input.

## Interface
- `STEP_CYCLES`, default 5_000_000: clock cycles per animation step; also the lockout length. Must be ≥ 2.
- `ROLL_STEPS`, default 16: number of animation steps per roll. Must be ≥ 1.
- `clk` in 1: system clock; all state changes on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `stop` in 1: pause, active-high, sampled synchronously. Freezes all state.
- `btn` in 1: debounced button level from the debouncer.
- `dice_val` out 3: current face value, always in 1..6.
- `rolling` out 1: high while the FSM is in ROLL.
- `done` out 1: one-cycle pulse when the final value is latched.
- `roll_count` out 8: number of completed rolls, wraps 255→0.

## Operation
- Reset (`rst_n` low, asynchronous) sets:
  - `dice_val`=1, `rolling`=0, `done`=0, `roll_count`=0;
  - FSM=IDLE, `seed`=1, `btn_q`=0, `div_cnt`=0, `step_cnt`=0.
- `btn_q` is registered `btn`. It updates every cycle, including while `stop` is high.
  - `rise` = `btn` & ~`btn_q`.
  - A rise that coincides with `stop` high is discarded, not deferred.
- `seed` is a 3-bit free-running counter 1→2→…→6→1.
  - Advances every cycle with `stop` low; holds while `stop` is high.
  - Values 0 and 7 are never reachable.
- FSM states:
  - IDLE: on `rise` → ROLL. Clear `div_cnt` and `step_cnt`; `rolling`←1.
  - ROLL: `div_cnt` increments each cycle. When `div_cnt`==STEP_CYCLES-1:
    - `div_cnt`←0 and `dice_val`←`seed` (the pre-edge value);
    - if `step_cnt`==ROLL_STEPS-1: `done`←1, `rolling`←0, `roll_count`←`roll_count`+1, go to HOLD;
    - otherwise `step_cnt`++.
  - HOLD: `div_cnt` counts to STEP_CYCLES-1, then returns to IDLE with `div_cnt`←0.
- Presses during ROLL or HOLD are ignored. A button still held at IDLE entry does not start a roll; a new rising edge is required.
- `done` is 0 on every cycle except the final-step edge.
- `stop` high freezes FSM state, `seed`, `div_cnt`, `step_cnt`, `dice_val`, `rolling` and `roll_count`, and forces `done`=0.
  - If `stop` is high on the final-step edge, the completion is deferred until the first unstopped cycle with that count.
  - When `stop` falls, counting resumes exactly where it froze.
- Reset mid-roll aborts immediately. No `done` pulse and no count increment occur.
- Counter widths: `div_cnt` is $clog2(STEP_CYCLES) bits and `step_cnt` is $clog2(ROLL_STEPS)+1 bits. Neither may overflow for legal parameters.

## Timing
- All outputs are registered; there is no combinational path from input to output.
- `rise` sampled at edge E0 gives `rolling`=1 after E0 (1-cycle latency).
- The k-th `dice_val` update happens at edge E0+k·STEP_CYCLES, for k=1..ROLL_STEPS, with `stop` low throughout.
- Final update, `done` pulse, `rolling` fall and `roll_count` increment all happen at the same edge: E0+ROLL_STEPS·STEP_CYCLES.
- HOLD lasts STEP_CYCLES cycles. The earliest next accepted rise is at edge E0+(ROLL_STEPS+1)·STEP_CYCLES+1.
- With `stop` low since reset release, `seed` read at edge n (counted from the first edge after release) is ((n-1) mod 6)+1.

## Test plan
All scenarios use STEP_CYCLES=4 and ROLL_STEPS=3.
- Basic roll: release reset, then rise detected at edge 10 →
  - `rolling`=1 after edge 10;
  - `dice_val`=2 at edge 14, 6 at edge 18, 4 at edge 22;
  - `done`=1 only at edge 22; `rolling`=0 and `roll_count`=1 after edge 22.
- Lockout: second rise at edge 24 → ignored, `roll_count` stays 1. A fresh rise at edge 27 → accepted, `rolling`=1 after edge 27.
- Pause: `stop` high for edges 15–19 during the basic roll →
  - `dice_val`, `seed` and counters frozen; `done`=0;
  - final update moves to edge 27, with `dice_val`=((26-5) mod 6)+1=4.
- Held button: `btn` held high across the whole roll and HOLD → no second roll until `btn` goes low and rises again.
- Reset mid-roll: `rst_n` low at edge 16 → immediately `dice_val`=1, `rolling`=0, `roll_count`=0; no `done` pulse.
- Wrap: 256 complete rolls → `roll_count` reads 0, and `dice_val` is always in 1..6 (asserted every cycle).
